// File: rtl/sample_delay_aligner.sv
// sample_delay_aligner
//   Valid-gated, runtime-programmable sample delay for CHANNELS lockstep
//   streams. A peak marker is carried with each stored sample, so it comes
//   out aligned with the sample it was captured against.
// Ports:
//   clk_i, reset_ni           clock, synchronous active-low reset
//   s_axis_in_tdata/tvalid    input samples (channel c at [c*IN_DW +: IN_DW])
//   marker_i                  single-cycle event pulse
//   delay_i, delay_load_i     requested delay in samples and its load strobe
//   m_axis_out_tdata/tvalid   delayed samples, 1 clock after the accept
//   marker_o                  marker aligned to the output sample
//   primed_o                  buffer holds at least 'delay' samples
//   fill_o                    accepted samples stored, saturating at MAX_DELAY
module sample_delay_aligner #(
  parameter int IN_DW         = 32,
  parameter int CHANNELS      = 1,
  parameter int MAX_DELAY     = 64,
  parameter int DEFAULT_DELAY = 14,
  localparam int DELAY_W      = $clog2(MAX_DELAY + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [CHANNELS*IN_DW-1:0] s_axis_in_tdata,
  input  logic                      s_axis_in_tvalid,
  input  logic                      marker_i,
  input  logic [DELAY_W-1:0]        delay_i,
  input  logic                      delay_load_i,
  output logic [CHANNELS*IN_DW-1:0] m_axis_out_tdata,
  output logic                      m_axis_out_tvalid,
  output logic                      marker_o,
  output logic                      primed_o,
  output logic [DELAY_W-1:0]        fill_o
);

  localparam int DW    = CHANNELS * IN_DW;
  localparam int PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int AW    = DELAY_W + 1;
  localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);
  localparam logic [DELAY_W-1:0] DEF_D = DELAY_W'(DEFAULT_DELAY);

  // Each entry: {marker, channel vector}
  logic [DW:0]          mem_q [MAX_DELAY];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [DELAY_W-1:0]   fill_q, fill_d;
  logic                 sticky_q, sticky_d;
  logic                 primed_q, primed_d;
  logic [DW-1:0]        tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 marker_q, marker_d;

  logic                 mark_in;
  logic [AW-1:0]        rd_raw, rd_wrap;
  logic [PTR_W-1:0]     rd_addr;
  logic [DW:0]          rd_ent;

  always_comb begin
    delay_d = delay_q;
    if (delay_load_i) begin
      delay_d = (delay_i > MAX_D) ? MAX_D : delay_i;
    end

    mark_in = sticky_q | marker_i;

    // (wr_ptr - delay) mod MAX_DELAY without a divider: bias by MAX_DELAY,
    // then one conditional subtract. delay == MAX_DELAY lands on wr_ptr,
    // i.e. the entry about to be overwritten (read-before-write).
    rd_raw  = AW'(wr_ptr_q) + AW'(MAX_DELAY) - AW'(delay_d);
    rd_wrap = (rd_raw >= AW'(MAX_DELAY)) ? (rd_raw - AW'(MAX_DELAY)) : rd_raw;
    rd_addr = rd_wrap[PTR_W-1:0];

    // Delay 0 bypasses the RAM with the live input and its marker.
    rd_ent = (delay_d == '0) ? {mark_in, s_axis_in_tdata} : mem_q[rd_addr];

    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    sticky_d = sticky_q;
    tvalid_d = 1'b0;
    marker_d = 1'b0;
    tdata_d  = tdata_q;

    if (s_axis_in_tvalid) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + 1'b1;
      sticky_d = 1'b0;
      if (fill_q != MAX_D) begin
        fill_d = fill_q + 1'b1;
      end
      if (fill_q >= delay_d) begin
        tvalid_d = 1'b1;
        tdata_d  = rd_ent[DW-1:0];
        marker_d = rd_ent[DW];
      end
    end else if (marker_i) begin
      sticky_d = 1'b1;
    end

    primed_d = (fill_d >= delay_d);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      delay_q  <= DEF_D;
      fill_q   <= '0;
      sticky_q <= 1'b0;
      primed_q <= (DEFAULT_DELAY == 0);
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      marker_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      delay_q  <= delay_d;
      fill_q   <= fill_d;
      sticky_q <= sticky_d;
      primed_q <= primed_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      marker_q <= marker_d;
    end
  end

  // RAM contents are not reset; fill gating keeps stale entries unread.
  always_ff @(posedge clk_i) begin
    if (reset_ni && s_axis_in_tvalid) begin
      mem_q[wr_ptr_q] <= {mark_in, s_axis_in_tdata};
    end
  end

  assign m_axis_out_tdata  = tdata_q;
  assign m_axis_out_tvalid = tvalid_q;
  assign marker_o          = marker_q;
  assign primed_o          = primed_q;
  assign fill_o            = fill_q;

endmodule

// File: doc/sample_delay_aligner.md
# sample_delay_aligner

Parametrised, valid-gated sample delay buffer for the SSB receive chain. It replaces the fixed clock-counted delay line that sits between the raw input stream and `frame_sync`. Delay is counted in accepted samples rather than clocks, and is runtime-programmable up to `MAX_DELAY`. The block carries `CHANNELS` antenna streams in lockstep and re-times a peak-marker pulse (`N_id_2_valid`) onto the delayed sample stream, so `frame_sync` receives the detection event aligned with the sample that caused it.

## Interface
Parameters:
- `IN_DW`, 32: width of one complex sample (imag MSBs, real LSBs).
- `CHANNELS`, 1: number of parallel streams sharing one valid.
- `MAX_DELAY`, 64: buffer depth in samples; must be ≥ 1.
- `DEFAULT_DELAY`, 14: delay after reset; must be ≤ `MAX_DELAY`.
- `DELAY_W`, `$clog2(MAX_DELAY+1)` (localparam).

Ports:
- `clk_i`  in  1  clock.
- `reset_ni`  in  1  synchronous, active-low reset.
- `s_axis_in_tdata`  in  `CHANNELS*IN_DW`  channel c at bits `[c*IN_DW +: IN_DW]`.
- `s_axis_in_tvalid`  in  1  sample accept; no backpressure.
- `marker_i`  in  1  single-cycle event pulse, may occur in any cycle.
- `delay_i`  in  `DELAY_W`  requested delay in samples.
- `delay_load_i`  in  1  latch `delay_i`.
- `m_axis_out_tdata`  out  `CHANNELS*IN_DW`  delayed samples.
- `m_axis_out_tvalid`  out  1  delayed sample valid.
- `marker_o`  out  1  marker aligned to the output sample.
- `primed_o`  out  1  buffer holds ≥ delay samples.
- `fill_o`  out  `DELAY_W`  accepted samples stored, saturating at `MAX_DELAY`.

## Operation
- Circular buffer of `MAX_DELAY` entries. Each entry holds the full channel vector plus 1 marker bit.
- Write pointer advances by 1 per accepted sample and wraps from `MAX_DELAY-1` to 0.
- Read address = (wr_ptr − delay) mod `MAX_DELAY`, read-before-write. With delay = `MAX_DELAY`, the read returns the entry being overwritten.
- Delay 0 bypasses the RAM: the output is the current input, registered.
- Marker capture: `marker_i` sets a sticky flag. The flag is stored with the next accepted sample, including a sample accepted in the same cycle as the marker, then cleared. A marker that coincides with a valid attaches to that sample.
- Delay register: on `delay_load_i`, the register takes `min(delay_i, MAX_DELAY)`. When load and valid occur in the same cycle, the new delay applies to that sample.
- `fill` increments per accepted sample and saturates at `MAX_DELAY`. `primed` = (fill ≥ delay), evaluated with the current delay and fill before the increment, plus the sample being accepted.
- Output occurs only when the accepted sample makes primed true. Unprimed accepted samples are written but produce no output.
- Increasing the delay beyond fill drops `primed_o` until enough samples arrive; no data reordering occurs. Decreasing the delay keeps `primed_o` and skips older samples immediately.
- Reset mid-stream: pointers, fill and the sticky marker are cleared; delay reverts to `DEFAULT_DELAY`. RAM contents are not cleared and are never output before being rewritten.

## Timing
- Latency: `m_axis_out_tvalid` is asserted exactly 1 clock after the accepting `s_axis_in_tvalid` cycle. It carries the sample accepted `delay` samples earlier; with delay 0 it carries the same sample.
- Throughput: 1 sample/clock sustained. Gaps in input valid produce identical gaps at the output.
- `primed_o` and `fill_o` are registered and update in the cycle after an accept or load.
- Reset values: `m_axis_out_tdata` 0, `m_axis_out_tvalid` 0, `marker_o` 0, `primed_o` = (`DEFAULT_DELAY` == 0), `fill_o` 0.
- `marker_o` is only ever high together with `m_axis_out_tvalid`.

## Test plan
- Default delay 14, continuous valid, ramp data 0,1,2,…: first output is value 0 at clock 15 after the first accept; `primed_o` rises after the 14th sample; output n = n−14 thereafter.
- Valid every 2nd clock, delay 14, `marker_i` pulsed in a gap cycle before sample 5: output valid alternates with a 1-cycle lag; `marker_o` accompanies output value 5 only.
- After priming at 14, load delay 20: `primed_o` drops; the next 6 accepts produce no output; output then resumes with offset 20. Load 4: output immediately jumps to offset 4 with no stall.
- `MAX_DELAY`=16, load 16, stream 40 samples: outputs are 0..23 with wrap-around correct; `delay_i`=31 saturates to 16.
- Delay 0 with a marker and valid in the same cycle: output equals input 1 clock later with `marker_o`=1.
- Reset asserted mid-stream after 30 samples: all outputs 0 the next cycle; after release, 14 new accepts occur before any output, and no stale data appears.
